// File: rtl/ret_stack_pkg.sv
// Constants shared along the CPU call/return path: PC width and the
// stack-op encoding used for the {push, pop} request pair.
package ret_stack_pkg;

  localparam int PC_W = 10;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_REPL = 2'b11;

endpackage

// File: rtl/ret_stack_if.sv
// Request/status bundle between the PC logic (master) and the return-address
// stack (slave). Requests apply at the next rising clk; status is registered.
interface ret_stack_if
  import ret_stack_pkg::*;
#(
  parameter int WIDTH = PC_W,
  parameter int DEPTH = 8
);

  localparam int AW = $clog2(DEPTH);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic             clr_err;
  logic [WIDTH-1:0] dout;
  logic [AW:0]      count;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;

  modport master (
    output push, pop, din, clr_err,
    input  dout, count, empty, full, ovf, unf
  );

  modport slave (
    input  push, pop, din, clr_err,
    output dout, count, empty, full, ovf, unf
  );

endinterface

// File: rtl/ret_stack_mem.sv
// Unreset register array for the return stack: one synchronous write port
// and one asynchronous read port.
module ret_stack_mem #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]           rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Non-power-of-two depths leave unused address codes; read those as zero.
  assign rdata = ({1'b0, raddr} < DEPTH_C) ? mem[raddr] : '0;

endmodule

// File: rtl/ret_stack.sv
// Return-address stack: pointer and sticky-flag control around ret_stack_mem.
// The top entry is always presented on dout, so a pop consumes it in-cycle.
module ret_stack
  import ret_stack_pkg::*;
#(
  parameter int WIDTH = PC_W,
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  ret_stack_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW:0]      sp;
  logic             ovf_q;
  logic             unf_q;
  logic [1:0]       op;
  logic             empty;
  logic             full;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    top;
  logic [WIDTH-1:0] rdata;

  assign op    = {bus.push, bus.pop};
  assign empty = (sp == '0);
  assign full  = (sp == DEPTH_C);
  assign top   = AW'(sp - ONE);

  // Writes go to the free slot on a push, or over the top entry on a replace.
  always_comb begin
    we    = 1'b0;
    waddr = AW'(sp);
    case (op)
      OP_PUSH: we = !full;
      OP_REPL: begin
        we    = !empty;
        waddr = top;
      end
      default: we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp    <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.clr_err) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end
      // A fresh error below overrides the clear issued in the same cycle.
      case (op)
        OP_NONE: ;
        OP_PUSH: begin
          if (!full) sp <= sp + ONE;
          else       ovf_q <= 1'b1;
        end
        OP_POP: begin
          if (!empty) sp <= sp - ONE;
          else        unf_q <= 1'b1;
        end
        OP_REPL: begin
          if (empty) unf_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  ret_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (bus.din),
    .raddr (top),
    .rdata (rdata)
  );

  assign bus.dout  = empty ? '0 : rdata;
  assign bus.count = sp;
  assign bus.empty = empty;
  assign bus.full  = full;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;

endmodule

// File: tb/tb_ret_stack.sv
// Directed and random checks of ret_stack: reset, LIFO order, overflow,
// underflow, replace-top, async reset, with a queue of expected pop values.
module tb_ret_stack;

  localparam int WIDTH = 10;
  localparam int DEPTH = 8;

  logic clk;
  logic reset;

  int vectors;
  int miscompares;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] model[$];

  ret_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  ret_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: a plain pop must present the expected top on dout before the edge.
  always @(negedge clk) begin
    if (reset && bus.pop && !bus.push && exp_q.size() > 0) begin
      logic [WIDTH-1:0] e;
      e = exp_q.pop_front();
      vectors++;
      if (bus.dout !== e) begin
        $display("FAIL pop_dout got %h want %h", bus.dout, e);
        miscompares++;
      end
    end
  end

  // Driver: called at posedge+1, holds the request for one clock edge and
  // keeps the reference stack plus expected pop values up to date.
  task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d,
                      input logic c);
    bus.push    = p;
    bus.pop     = q;
    bus.din     = d;
    bus.clr_err = c;
    if (p && !q && model.size() < DEPTH) model.push_back(d);
    if (!p && q && model.size() > 0) begin
      exp_q.push_back(model[$]);
      void'(model.pop_back());
    end
    if (p && q && model.size() > 0) model[$] = d;
    @(posedge clk);
    #1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.din = '0; bus.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (bus.count !== 4'd0) begin $display("FAIL reset_count got %0d want 0", bus.count); miscompares++; end
    vectors++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      $display("FAIL reset_empty_full got %b%b want 10", bus.empty, bus.full); miscompares++;
    end
    vectors++;
    if (bus.dout !== 10'h000) begin $display("FAIL reset_dout got %h want 000", bus.dout); miscompares++; end
    vectors++;
    if (bus.ovf !== 1'b0 || bus.unf !== 1'b0) begin
      $display("FAIL reset_flags got %b%b want 00", bus.ovf, bus.unf); miscompares++;
    end
  endtask

  task automatic test_lifo();
    step(1, 0, 10'h005, 0);
    step(1, 0, 10'h00A, 0);
    step(1, 0, 10'h3FF, 0);
    vectors++;
    if (bus.dout !== 10'h3FF || bus.count !== 4'd3) begin
      $display("FAIL lifo_top got %h/%0d want 3ff/3", bus.dout, bus.count); miscompares++;
    end
    repeat (3) step(0, 1, '0, 0);
    vectors++;
    if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin
      $display("FAIL lifo_drain got %0d/%b want 0/1", bus.count, bus.empty); miscompares++;
    end
    vectors++;
    if (bus.ovf !== 1'b0 || bus.unf !== 1'b0) begin
      $display("FAIL lifo_flags got %b%b want 00", bus.ovf, bus.unf); miscompares++;
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= DEPTH; i++) step(1, 0, WIDTH'(i), 0);
    vectors++;
    if (bus.full !== 1'b1 || bus.count !== 4'd8) begin
      $display("FAIL fill got %b/%0d want 1/8", bus.full, bus.count); miscompares++;
    end
    step(1, 0, 10'h123, 0);
    vectors++;
    if (bus.count !== 4'd8 || bus.ovf !== 1'b1 || bus.full !== 1'b1) begin
      $display("FAIL ovf_set got %0d/%b/%b want 8/1/1", bus.count, bus.ovf, bus.full); miscompares++;
    end
    vectors++;
    if (bus.dout !== 10'd8) begin $display("FAIL ovf_dout got %h want 008", bus.dout); miscompares++; end
    step(0, 0, '0, 1);
    vectors++;
    if (bus.ovf !== 1'b0) begin $display("FAIL ovf_clear got %b want 0", bus.ovf); miscompares++; end
    step(0, 1, '0, 0);
    vectors++;
    if (bus.dout !== 10'd7 || bus.count !== 4'd7) begin
      $display("FAIL ovf_pop got %h/%0d want 007/7", bus.dout, bus.count); miscompares++;
    end
    repeat (7) step(0, 1, '0, 0);
  endtask

  task automatic test_underflow();
    step(0, 1, '0, 0);
    vectors++;
    if (bus.unf !== 1'b1 || bus.count !== 4'd0) begin
      $display("FAIL unf_set got %b/%0d want 1/0", bus.unf, bus.count); miscompares++;
    end
    step(0, 1, '0, 1);
    vectors++;
    if (bus.unf !== 1'b1) begin $display("FAIL unf_error_wins got %b want 1", bus.unf); miscompares++; end
    step(0, 0, '0, 1);
    vectors++;
    if (bus.unf !== 1'b0) begin $display("FAIL unf_clear got %b want 0", bus.unf); miscompares++; end
  endtask

  task automatic test_replace();
    step(1, 0, 10'h010, 0);
    step(1, 0, 10'h020, 0);
    step(1, 1, 10'h111, 0);
    vectors++;
    if (bus.count !== 4'd2 || bus.dout !== 10'h111) begin
      $display("FAIL repl_top got %0d/%h want 2/111", bus.count, bus.dout); miscompares++;
    end
    step(0, 1, '0, 0);
    vectors++;
    if (bus.dout !== 10'h010) begin $display("FAIL repl_pop got %h want 010", bus.dout); miscompares++; end
    step(0, 1, '0, 0);
    step(1, 1, 10'h222, 0);
    vectors++;
    if (bus.unf !== 1'b1 || bus.count !== 4'd0 || bus.dout !== 10'h000) begin
      $display("FAIL repl_empty got %b/%0d/%h want 1/0/000", bus.unf, bus.count, bus.dout); miscompares++;
    end
    step(0, 0, '0, 1);
  endtask

  task automatic test_async_reset();
    step(1, 0, 10'h0A1, 0);
    step(1, 0, 10'h0A2, 0);
    step(1, 0, 10'h0A3, 0);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin
      $display("FAIL async_reset got %0d/%b want 0/1", bus.count, bus.empty); miscompares++;
    end
    model.delete();
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    step(1, 0, 10'h055, 0);
    vectors++;
    if (bus.dout !== 10'h055 || bus.count !== 4'd1) begin
      $display("FAIL post_reset_push got %h/%0d want 055/1", bus.dout, bus.count); miscompares++;
    end
    step(0, 1, '0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      logic p, q;
      logic [WIDTH-1:0] d, want;
      p = 1'($urandom_range(0, 1));
      q = 1'($urandom_range(0, 1));
      d = WIDTH'($urandom_range(0, 1023));
      step(p, q, d, 1);
      want = (model.size() > 0) ? model[$] : '0;
      vectors++;
      if (bus.count !== 4'(model.size()) || bus.dout !== want) begin
        $display("FAIL rand_%0d got %0d/%h want %0d/%h", i, bus.count, bus.dout, model.size(), want);
        miscompares++;
      end
    end
    while (model.size() > 0) step(0, 1, '0, 0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_lifo();
    test_overflow();
    test_underflow();
    test_replace();
    test_async_reset();
    test_back_to_back();
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      $display("FAIL pending_pops got %0d want 0", exp_q.size()); miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
